// File: rtl/bird_motion.sv
// bird_motion: vertical physics engine for the bird sprite.
// Integrates gravity and jump impulses once per physics tick and reports the
// bird row, its signed velocity (positive = down) and a sticky ground-hit flag.
// Optional feature macro: BIRD_HOVER_EN adds an idle triangle-wave bob of
// +/-HOVER_AMP rows around Y_START while the game has not started.
// jump handshake: jump is a one-cycle pulse with no ready/ack; it is only
// meaningful in a cycle where state == GAME and is otherwise dropped.
// dbg_state exposes the internal FSM (0 IDLE, 1 FLY, 2 DEAD).
module bird_motion #(
  parameter int TICK_DIV  = 650000,
  parameter int Y_START   = 240,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 440,
  parameter int GRAVITY   = 1,
  parameter int JUMP_VEL  = 8,
  parameter int V_MAX     = 10,
  parameter int HOVER_AMP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              game_rst,
  input  logic [1:0]        state,
  input  logic              jump,
  output logic [10:0]       bird_y,
  output logic signed [7:0] bird_vel,
  output logic              ground_hit,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]     TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [10:0]       Y_SPAWN   = 11'(Y_START);
  localparam logic [10:0]       Y_CEIL    = 11'(Y_MIN);
  localparam logic [10:0]       Y_GROUND  = 11'(Y_MAX);
  localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic signed [8:0] VEL_GRAV  = 9'(GRAVITY);
  localparam logic signed [8:0] VEL_CAP   = 9'(V_MAX);
  localparam logic signed [7:0] VEL_JUMP  = 8'(-JUMP_VEL);

  // Parameter sanity: refuse to elaborate an inconsistent configuration.
  if (TICK_DIV < 2 || !(Y_MIN < Y_START && Y_START < Y_MAX && Y_MAX < 2048) ||
      JUMP_VEL > 127 || V_MAX > 127 ||
      Y_START - HOVER_AMP < Y_MIN || Y_START + HOVER_AMP > Y_MAX) begin : g_bad_params
    $error("bird_motion: inconsistent parameters");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLY = 2'd1, S_DEAD = 2'd2} fsm_t;

  fsm_t                fsm_q, fsm_d;
  logic [CW-1:0]       cnt_q;
  logic                tick;
  logic                jump_pending, pend_d;
  logic [10:0]         y_d;
  logic signed [7:0]   vel_d;
  logic                hit_d;
  logic signed [11:0]  y_sum;
  logic signed [8:0]   vel_inc;
  logic signed [7:0]   vel_fall;
  logic                st_game, st_over, st_start, jump_ok;

`ifdef BIRD_HOVER_EN
  localparam logic [10:0] Y_HOV_HI = 11'(Y_START + HOVER_AMP);
  localparam logic [10:0] Y_HOV_LO = 11'(Y_START - HOVER_AMP);
  logic hov_down_q, hov_down_d;
`endif

  assign st_game   = (state == 2'b01);
  assign st_over   = (state == 2'b10);
  assign st_start  = (state == 2'b00) || (state == 2'b11);
  assign jump_ok   = jump && st_game;
  assign tick      = (cnt_q == TICK_LAST);
  assign dbg_state = fsm_q;

  // Physics tick divider; restarts from zero on any reset.
  always_ff @(posedge clk) begin
    if (rst || game_rst) cnt_q <= '0;
    else if (tick)       cnt_q <= '0;
    else                 cnt_q <= cnt_q + 1'b1;
  end

  // FSM next state plus next values of every output register.
  always_comb begin
    fsm_d  = fsm_q;
    y_d    = bird_y;
    vel_d  = bird_vel;
    hit_d  = ground_hit;
    pend_d = jump_pending;
`ifdef BIRD_HOVER_EN
    hov_down_d = hov_down_q;
`endif
    // Old velocity moves the bird; 12-bit signed so the ceiling can be seen.
    y_sum    = $signed({1'b0, bird_y}) + $signed({{4{bird_vel[7]}}, bird_vel});
    vel_inc  = $signed({bird_vel[7], bird_vel}) + VEL_GRAV;
    vel_fall = (vel_inc > VEL_CAP) ? VEL_CAP[7:0] : vel_inc[7:0];

    case (fsm_q)
      S_IDLE: begin
        vel_d  = '0;
        hit_d  = 1'b0;
        pend_d = 1'b0;
`ifdef BIRD_HOVER_EN
        if (tick) begin
          if (hov_down_q) begin
            y_d = bird_y + 11'd1;
            if (bird_y + 11'd1 >= Y_HOV_HI) hov_down_d = 1'b0;
          end else begin
            y_d = bird_y - 11'd1;
            if (bird_y - 11'd1 <= Y_HOV_LO) hov_down_d = 1'b1;
          end
        end
`else
        y_d = Y_SPAWN;
`endif
        // The controller raises the first jump together with GAME.
        if (st_game) begin
          fsm_d  = S_FLY;
          pend_d = jump_ok;
        end
      end
      S_FLY, S_DEAD: begin
        if (st_start) begin
          fsm_d  = S_IDLE;
          y_d    = Y_SPAWN;
          vel_d  = '0;
          hit_d  = 1'b0;
          pend_d = 1'b0;
`ifdef BIRD_HOVER_EN
          hov_down_d = 1'b1;
`endif
        end else begin
          if (tick) begin
            pend_d = 1'b0;
            vel_d  = (fsm_q == S_FLY && (jump_pending || jump_ok)) ? VEL_JUMP : vel_fall;
            y_d    = y_sum[10:0];
            if (y_sum < Y_MIN_S) begin
              y_d   = Y_CEIL;
              vel_d = '0;
            end else if (y_sum >= Y_MAX_S) begin
              y_d   = Y_GROUND;
              vel_d = '0;
              if (fsm_q == S_FLY) hit_d = 1'b1;
            end
          end else if (fsm_q == S_FLY) begin
            pend_d = jump_pending || jump_ok;
          end
          if (fsm_q == S_FLY && st_over) begin
            fsm_d  = S_DEAD;
            pend_d = 1'b0;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // State and output registers; rst and game_rst both respawn the bird.
  always_ff @(posedge clk) begin
    if (rst || game_rst) begin
      fsm_q        <= S_IDLE;
      bird_y       <= Y_SPAWN;
      bird_vel     <= '0;
      ground_hit   <= 1'b0;
      jump_pending <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      bird_y       <= y_d;
      bird_vel     <= vel_d;
      ground_hit   <= hit_d;
      jump_pending <= pend_d;
    end
  end

`ifdef BIRD_HOVER_EN
  // Hover direction; the first bob step after a respawn goes down.
  always_ff @(posedge clk) begin
    if (rst || game_rst) hov_down_q <= 1'b1;
    else                 hov_down_q <= hov_down_d;
  end
`endif

endmodule
